time_counter: RTL and testbench
===============================

Name: time_counter

Overview:
- Wall-clock time-of-day counter driven by a single free-running system clock.
- An internal prescaler divides the clock down to a 1 Hz tick; cascaded seconds, minutes and hours counters advance on that tick.
- Sits behind the board clock source (nominal 250 Hz, one clock every 4 ms) and feeds the display/alarm logic with binary H:M:S values.

Parameters:
- CLKS_PER_SEC, 250, number of clk rising edges per one-second tick; legal range 1 to 2^16-1.
- SEC_MAX, 60, seconds modulus; seconds count 0 to SEC_MAX-1.
- MIN_MAX, 60, minutes modulus; minutes count 0 to MIN_MAX-1.
- HOUR_MAX, 24, hours modulus; hours count 0 to HOUR_MAX-1.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high; clears all state immediately.
- secs, output, 6, current seconds, binary 0..59.
- mins, output, 6, current minutes, binary 0..59.
- hours, output, 6, current hours, binary 0..23.
- Positional instantiation order is secs, mins, hours, reset, clk.

Behaviour:
- Reset (asynchronous, active-high):
  - While reset is 1: prescaler, secs, mins and hours are all 0, independent of clk.
  - Release takes effect at the first clk rising edge after reset falls.
  - A reset asserted mid-count discards the partial second; counting restarts from 00:00:00 with a full CLKS_PER_SEC period.
- Prescaler:
  - Width is ceil(log2(CLKS_PER_SEC)) bits.
  - Counts 0 to CLKS_PER_SEC-1 on every rising clk edge, then wraps to 0.
  - An internal one-cycle tick is asserted in the cycle where the prescaler equals CLKS_PER_SEC-1.
  - CLKS_PER_SEC=1 gives a tick every cycle.
- Seconds:
  - On the edge where tick=1, secs increments.
  - At SEC_MAX-1 it wraps to 0 and raises a carry.
- Minutes:
  - Increment only on the same edge as a seconds carry.
  - Wrap at MIN_MAX-1 to 0 and raise a carry.
- Hours:
  - Increment only on the same edge as a minutes carry.
  - Wrap at HOUR_MAX-1 to 0; no further carry.
- Cascade timing:
  - All carries are combinational from the current counter values plus tick.
  - Every counter affected by one tick updates on the same clock edge.
  - Example: 00:59:59 becomes 01:00:00 in a single edge; 23:59:59 becomes 00:00:00 in a single edge.
- Output timing:
  - Outputs are registered, with no combinational path from reset-release or clk to outputs except register clock-to-q.
  - Latency: secs first changes from 0 to 1 on the CLKS_PER_SEC-th rising edge after reset release.
- Value range:
  - Outputs never exceed their modulus-1.
  - Unused upper codes (60..63, 24..63) are unreachable from reset.
  - If ever loaded with such a code (e.g. X-recovery), the next increment of that field forces it to 0 and generates a carry.
- No enable, load or set inputs: time setting is out of scope for this block.

Test Plan:
- Reset held: reset=1 for 10 clks → secs=mins=hours=0 throughout, prescaler static at 0.
- Async reset: assert reset between clk edges while secs=5 → all outputs 0 immediately, before the next edge; after release, secs=1 exactly 250 edges later.
- Seconds cadence: release reset, run 250*10 clks → secs=10, mins=0, hours=0; secs changes only every 250th edge.
- Minute rollover: run 60*250 clks from reset → secs=0, mins=1 on the same edge where secs wraps 59→0.
- Hour rollover: use CLKS_PER_SEC=1, run 3600 clks → 01:00:00, reached from 00:59:59 in one edge.
- Day wrap: use CLKS_PER_SEC=1, run 86400 clks → 00:00:00, preceded by 23:59:59; hours never shows 24.

Source files
------------

// File: rtl/time_counter.sv
// time_counter: wall-clock time-of-day counter (binary H:M:S).
// Latency: secs first increments on the CLKS_PER_SEC-th rising clk edge after reset release.
// Backpressure: none; free-running, outputs are plain registers updated on the 1 Hz tick.
//
// Ports:
//   secs   - current seconds, 0..SEC_MAX-1
//   mins   - current minutes, 0..MIN_MAX-1
//   hours  - current hours,   0..HOUR_MAX-1
//   reset  - asynchronous, active-high clear of all state
//   clk    - system clock, all updates on the rising edge
module time_counter #(
  parameter int unsigned CLKS_PER_SEC = 250,
  parameter int unsigned SEC_MAX      = 60,
  parameter int unsigned MIN_MAX      = 60,
  parameter int unsigned HOUR_MAX     = 24
) (
  output logic [5:0] secs,
  output logic [5:0] mins,
  output logic [5:0] hours,
  input  logic       reset,
  input  logic       clk
);

  // A divide-by-1 prescaler still needs one bit of storage; it simply never
  // leaves 0 because the tick compare is satisfied at 0.
  localparam int unsigned PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_SEC - 1);
  localparam logic [5:0]    SEC_LAST   = 6'(SEC_MAX - 1);
  localparam logic [5:0]    MIN_LAST   = 6'(MIN_MAX - 1);
  localparam logic [5:0]    HOUR_LAST  = 6'(HOUR_MAX - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic          sec_wrap;
  logic          min_wrap;
  logic          hour_wrap;
  logic          sec_carry;
  logic          min_carry;

  // ">=" rather than "==" so any out-of-range code (e.g. after X recovery)
  // is treated as the last value: the next increment forces 0 and carries.
  always_comb begin
    tick      = (presc >= PRESC_LAST);
    sec_wrap  = (secs  >= SEC_LAST);
    min_wrap  = (mins  >= MIN_LAST);
    hour_wrap = (hours >= HOUR_LAST);
    sec_carry = tick & sec_wrap;
    min_carry = sec_carry & min_wrap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // All three fields update on the same edge, so 23:59:59 -> 00:00:00 is
  // one transition with no intermediate states visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      secs  <= '0;
      mins  <= '0;
      hours <= '0;
    end else begin
      if (tick) begin
        secs <= sec_wrap ? 6'd0 : secs + 6'd1;
      end
      if (sec_carry) begin
        mins <= min_wrap ? 6'd0 : mins + 6'd1;
      end
      if (min_carry) begin
        hours <= hour_wrap ? 6'd0 : hours + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter: a 250-clk/s instance and a 1-clk/s instance
// share one clock; the fast one covers hour and day rollover while the
// slow one covers reset, cadence, minute rollover and async reset.
module tb_time_counter;

  logic       clk;
  logic       reset_main;
  logic       reset_fast;
  logic [5:0] secs_m, mins_m, hours_m;
  logic [5:0] secs_f, mins_f, hours_f;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;   // edges since fast-instance reset release
  int hmax_fast  = 0;   // largest hours value seen on the fast instance

  time_counter #(.CLKS_PER_SEC(250)) u_main (
    .secs(secs_m), .mins(mins_m), .hours(hours_m), .reset(reset_main), .clk(clk)
  );

  time_counter #(.CLKS_PER_SEC(1)) u_fast (
    .secs(secs_f), .mins(mins_f), .hours(hours_f), .reset(reset_fast), .clk(clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, sampling 1 time unit after each edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (int'(hours_f) > hmax_fast) hmax_fast = int'(hours_f);
    end
  endtask

  function automatic logic [31:0] hms(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    return {14'd0, h, m, s};
  endfunction

  initial begin
    reset_main = 1'b1;
    reset_fast = 1'b1;
    #2;

    // Reset held for 10 clocks: everything stays at zero.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold_main", hms(hours_m, mins_m, secs_m), hms(6'd0, 6'd0, 6'd0));
      check("reset_hold_presc", 32'(u_main.presc), 32'd0);
    end
    check("reset_hold_fast", hms(hours_f, mins_f, secs_f), hms(6'd0, 6'd0, 6'd0));

    // Release both just after an edge; next edge is edge 1.
    reset_main = 1'b0;
    reset_fast = 1'b0;
    cyc = 0;

    step(249);
    check("first_sec_not_yet", 32'(secs_m), 32'd0);
    check("presc_at_249", 32'(u_main.presc), 32'd249);
    step(1);
    check("first_sec_edge250", 32'(secs_m), 32'd1);

    step(2249);   // edge 2499
    check("cadence_2499", hms(hours_m, mins_m, secs_m), hms(6'd0, 6'd0, 6'd9));
    step(1);      // edge 2500
    check("cadence_2500", hms(hours_m, mins_m, secs_m), hms(6'd0, 6'd0, 6'd10));

    step(1099);   // edge 3599
    check("fast_pre_hour", hms(hours_f, mins_f, secs_f), hms(6'd0, 6'd59, 6'd59));
    step(1);      // edge 3600
    check("fast_hour_roll", hms(hours_f, mins_f, secs_f), hms(6'd1, 6'd0, 6'd0));

    step(11399);  // edge 14999
    check("main_pre_min", hms(hours_m, mins_m, secs_m), hms(6'd0, 6'd0, 6'd59));
    step(1);      // edge 15000
    check("main_min_roll", hms(hours_m, mins_m, secs_m), hms(6'd0, 6'd1, 6'd0));

    step(1250);   // edge 16250: 00:01:05
    check("main_before_async", hms(hours_m, mins_m, secs_m), hms(6'd0, 6'd1, 6'd5));

    // Assert reset between edges; outputs must clear before the next edge.
    #2;
    reset_main = 1'b1;
    #1;
    check("async_clear", hms(hours_m, mins_m, secs_m), hms(6'd0, 6'd0, 6'd0));
    check("async_presc", 32'(u_main.presc), 32'd0);
    step(1);
    reset_main = 1'b0;
    step(249);
    check("async_restart_249", 32'(secs_m), 32'd0);
    step(1);
    check("async_restart_250", hms(hours_m, mins_m, secs_m), hms(6'd0, 6'd0, 6'd1));

    // Fast instance: run to one edge before the day wrap.
    step(86399 - cyc);
    check("fast_pre_day", hms(hours_f, mins_f, secs_f), hms(6'd23, 6'd59, 6'd59));
    step(1);
    check("fast_day_wrap", hms(hours_f, mins_f, secs_f), hms(6'd0, 6'd0, 6'd0));
    check("fast_hours_max", 32'(hmax_fast), 32'd23);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
